fmul_pipe: RTL and testbench

FMUL_PIPE -- requirements
Module: fmul_pipe

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_round.sv | 96 +++++++++
 rtl/fmul_pipe.sv | 198 +++++++++++++++++++
 tb/tb_fmul_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: exception flag positions, rounding-mode
// encodings and the canonical quiet-NaN pattern for any exponent/fraction split.
package fp_pkg;

    localparam int NFLAGS  = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rm_e;

    localparam int QNAN_MAXW = 128;

    // Positive sign, all-ones exponent, fraction MSB set; callers slice to their width.
    function automatic logic [QNAN_MAXW-1:0] fp_qnan(input int exp_w, input int frac_w);
        logic [QNAN_MAXW-1:0] v;
        v = '0;
        for (int k = 0; k < exp_w + 1; k++) begin
            v[frac_w - 1 + k] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational normalize/round/pack for a full-width significand product;
// selects Inf/max-finite on overflow and signed zero on underflow.
module fp_round
    import fp_pkg::*;
#(
    parameter int EXP   = 8,
    parameter int FRAC  = 23,
    parameter int WIDTH = EXP + FRAC + 1
) (
    input  logic                  i_sign,
    input  logic signed [EXP+1:0] i_exp,
    input  logic [2*FRAC+1:0]     i_prod,
    input  rm_e                   i_rm,
    output logic [WIDTH-1:0]      o_res,
    output logic [NFLAGS-1:0]     o_flags
);

    localparam int EW  = EXP + 2;
    localparam int PW  = 2 * FRAC + 2;
    localparam int LZW = $clog2(PW + 1);
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP) - 1);

    logic [LZW-1:0]       w_lz;
    logic [PW-1:0]        w_norm;
    logic [FRAC:0]        w_mant;
    logic                 w_g;
    logic                 w_r;
    logic                 w_s;
    logic                 w_inexact;
    logic                 w_round_up;
    logic [FRAC+1:0]      w_mant_rnd;
    logic signed [EW-1:0] w_exp_norm;
    logic signed [EW-1:0] w_exp_rnd;
    logic                 w_uf;
    logic                 w_of;
    logic                 w_zero;
    logic                 w_to_inf;

    // Highest set bit wins; a product in [2,4) has lz=0 and keeps the +1 exponent step.
    always_comb begin
        w_lz = '0;
        for (int k = 0; k < PW; k++) begin
            if (i_prod[k]) begin
                w_lz = LZW'(PW - 1 - k);
            end
        end
    end

    assign w_norm     = i_prod << w_lz;
    assign w_mant     = w_norm[PW-1 -: FRAC+1];
    assign w_g        = w_norm[FRAC];
    assign w_r        = w_norm[FRAC-1];
    assign w_s        = |w_norm[FRAC-2:0];
    assign w_inexact  = w_g | w_r | w_s;
    assign w_exp_norm = i_exp + EW'(1) - EW'(w_lz);

    always_comb begin
        w_round_up = 1'b0;
        case (i_rm)
            RM_RNE:  w_round_up = w_g & (w_r | w_s | w_mant[0]);
            RM_RTZ:  w_round_up = 1'b0;
            RM_RDN:  w_round_up = w_inexact & i_sign;
            RM_RUP:  w_round_up = w_inexact & ~i_sign;
            default: w_round_up = 1'b0;
        endcase
    end

    assign w_mant_rnd = {1'b0, w_mant} + (FRAC+2)'(w_round_up);
    assign w_exp_rnd  = w_exp_norm + EW'(w_mant_rnd[FRAC+1]);
    assign w_zero     = ~w_mant_rnd[FRAC+1] & ~w_mant_rnd[FRAC];
    assign w_uf       = w_exp_norm[EW-1] | (w_exp_norm == '0);
    assign w_of       = ~w_exp_rnd[EW-1] & (w_exp_rnd >= EXP_MAX);
    assign w_to_inf   = (i_rm == RM_RNE) | ((i_rm == RM_RUP) & ~i_sign) |
                        ((i_rm == RM_RDN) & i_sign);

    always_comb begin
        o_res   = '0;
        o_flags = '0;
        if (w_zero) begin
            o_res = {i_sign, {(WIDTH-1){1'b0}}};
        end else if (w_uf) begin
            o_res            = {i_sign, {(WIDTH-1){1'b0}}};
            o_flags[FLAG_UF] = 1'b1;
            o_flags[FLAG_NX] = 1'b1;
        end else if (w_of) begin
            o_res = w_to_inf ? {i_sign, {EXP{1'b1}}, {FRAC{1'b0}}}
                             : {i_sign, {(EXP-1){1'b1}}, 1'b0, {FRAC{1'b1}}};
            o_flags[FLAG_OF] = 1'b1;
            o_flags[FLAG_NX] = 1'b1;
        end else begin
            o_res            = {i_sign, w_exp_rnd[EXP-1:0], w_mant_rnd[FRAC-1:0]};
            o_flags[FLAG_NX] = w_inexact;
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage floating-point multiplier with valid/ready flow control:
// S1 unpack/classify/exponent sum, S2 significand multiply, S3 round and pack.
module fmul_pipe
    import fp_pkg::*;
#(
    parameter int EXP   = 8,
    parameter int FRAC  = 23,
    parameter int WIDTH = EXP + FRAC + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [1:0]        round_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  r,
    output logic [NFLAGS-1:0] flags
);

    localparam int EW   = EXP + 2;
    localparam int PW   = 2 * FRAC + 2;
    localparam int BIAS = (1 << (EXP - 1)) - 1;
    localparam logic [QNAN_MAXW-1:0] QNAN_FULL = fp_qnan(EXP, FRAC);
    localparam logic [WIDTH-1:0]     QNAN      = QNAN_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] w_op      [2];
    logic [EXP-1:0]   w_eff_exp [2];
    logic [FRAC:0]    w_mant    [2];
    logic [1:0]       w_is_zero;
    logic [1:0]       w_is_inf;
    logic [1:0]       w_is_nan;

    assign w_op[0] = a;
    assign w_op[1] = b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [EXP-1:0]  w_e;
            logic [FRAC-1:0] w_f;
            assign w_e            = w_op[gi][WIDTH-2:FRAC];
            assign w_f            = w_op[gi][FRAC-1:0];
            assign w_is_zero[gi]  = (w_e == '0) & (w_f == '0);
            assign w_is_inf[gi]   = (&w_e) & (w_f == '0);
            assign w_is_nan[gi]   = (&w_e) & (|w_f);
            // Subnormals: hidden bit 0, exponent treated as 1.
            assign w_mant[gi]     = {|w_e, w_f};
            assign w_eff_exp[gi]  = (w_e == '0) ? EXP'(1) : w_e;
        end
    endgenerate

    logic                 w_sign;
    logic signed [EW-1:0] w_exp_sum;
    logic                 w_special;
    logic                 w_spec_nv;
    logic [WIDTH-1:0]     w_spec_res;

    assign w_sign    = w_op[0][WIDTH-1] ^ w_op[1][WIDTH-1];
    assign w_exp_sum = EW'(w_eff_exp[0]) + EW'(w_eff_exp[1]) - EW'(BIAS);

    always_comb begin
        w_special  = 1'b1;
        w_spec_nv  = 1'b0;
        w_spec_res = '0;
        if ((|w_is_nan) | ((|w_is_inf) & (|w_is_zero))) begin
            w_spec_res = QNAN;
            w_spec_nv  = 1'b1;
        end else if (|w_is_inf) begin
            w_spec_res = {w_sign, {EXP{1'b1}}, {FRAC{1'b0}}};
        end else if (|w_is_zero) begin
            w_spec_res = {w_sign, {(WIDTH-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    // Stage load enables: a stage loads when empty or when its content moves on.
    logic r_s1_valid, r_s2_valid, r_s3_valid;
    logic w_ld_s1, w_ld_s2, w_ld_s3;

    assign w_ld_s3   = ~r_s3_valid | out_ready;
    assign w_ld_s2   = ~r_s2_valid | w_ld_s3;
    assign w_ld_s1   = ~r_s1_valid | w_ld_s2;
    assign in_ready  = w_ld_s1;
    assign out_valid = r_s3_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            if (w_ld_s1) r_s1_valid <= in_valid;
            if (w_ld_s2) r_s2_valid <= r_s1_valid;
            if (w_ld_s3) r_s3_valid <= r_s2_valid;
        end
    end

    logic                 r_s1_sign;
    logic signed [EW-1:0] r_s1_exp;
    logic [FRAC:0]        r_s1_ma;
    logic [FRAC:0]        r_s1_mb;
    rm_e                  r_s1_rm;
    logic                 r_s1_special;
    logic                 r_s1_spec_nv;
    logic [WIDTH-1:0]     r_s1_spec_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_sign     <= 1'b0;
            r_s1_exp      <= '0;
            r_s1_ma       <= '0;
            r_s1_mb       <= '0;
            r_s1_rm       <= RM_RNE;
            r_s1_special  <= 1'b0;
            r_s1_spec_nv  <= 1'b0;
            r_s1_spec_res <= '0;
        end else if (w_ld_s1 && in_valid) begin
            r_s1_sign     <= w_sign;
            r_s1_exp      <= w_exp_sum;
            r_s1_ma       <= w_mant[0];
            r_s1_mb       <= w_mant[1];
            r_s1_rm       <= rm_e'(round_mode);
            r_s1_special  <= w_special;
            r_s1_spec_nv  <= w_spec_nv;
            r_s1_spec_res <= w_spec_res;
        end
    end

    logic                 r_s2_sign;
    logic signed [EW-1:0] r_s2_exp;
    logic [PW-1:0]        r_s2_prod;
    rm_e                  r_s2_rm;
    logic                 r_s2_special;
    logic                 r_s2_spec_nv;
    logic [WIDTH-1:0]     r_s2_spec_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_sign     <= 1'b0;
            r_s2_exp      <= '0;
            r_s2_prod     <= '0;
            r_s2_rm       <= RM_RNE;
            r_s2_special  <= 1'b0;
            r_s2_spec_nv  <= 1'b0;
            r_s2_spec_res <= '0;
        end else if (w_ld_s2 && r_s1_valid) begin
            r_s2_sign     <= r_s1_sign;
            r_s2_exp      <= r_s1_exp;
            r_s2_prod     <= {{(FRAC+1){1'b0}}, r_s1_ma} * {{(FRAC+1){1'b0}}, r_s1_mb};
            r_s2_rm       <= r_s1_rm;
            r_s2_special  <= r_s1_special;
            r_s2_spec_nv  <= r_s1_spec_nv;
            r_s2_spec_res <= r_s1_spec_res;
        end
    end

    logic [WIDTH-1:0]  w_rnd_res;
    logic [NFLAGS-1:0] w_rnd_flags;
    logic [NFLAGS-1:0] w_spec_flags;
    logic [WIDTH-1:0]  r_res;
    logic [NFLAGS-1:0] r_flags;

    fp_round #(
        .EXP   (EXP),
        .FRAC  (FRAC),
        .WIDTH (WIDTH)
    ) u_round (
        .i_sign  (r_s2_sign),
        .i_exp   (r_s2_exp),
        .i_prod  (r_s2_prod),
        .i_rm    (r_s2_rm),
        .o_res   (w_rnd_res),
        .o_flags (w_rnd_flags)
    );

    always_comb begin
        w_spec_flags          = '0;
        w_spec_flags[FLAG_NV] = r_s2_spec_nv;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res   <= '0;
            r_flags <= '0;
        end else if (w_ld_s3 && r_s2_valid) begin
            r_res   <= r_s2_special ? r_s2_spec_res : w_rnd_res;
            r_flags <= r_s2_special ? w_spec_flags  : w_rnd_flags;
        end
    end

    assign r     = r_res;
    assign flags = r_flags;

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe (FP32): directed vectors push expected results,
// a negedge monitor pops and compares every output transfer.
module tb_fmul_pipe;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RDN = 2'b10;
    localparam logic [1:0] RUP = 2'b11;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;
    logic [4:0]  flags;

    fmul_pipe #(.EXP(8), .FRAC(23), .WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .r          (r),
        .flags      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  f;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] r;
        logic [4:0]  f;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    task automatic add_vec(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] rm,
                           input logic [31:0] er, input logic [4:0] ef);
        vec_t v;
        v.a = va; v.b = vb; v.rm = rm; v.r = er; v.f = ef;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input int idx, output int waits);
        waits = 0;
        in_valid   = 1'b1;
        a          = vecs[idx].a;
        b          = vecs[idx].b;
        round_mode = vecs[idx].rm;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({vecs[idx].r, vecs[idx].f});
                $display("issue  #%0d a=%h b=%h rm=%b", idx, vecs[idx].a, vecs[idx].b, vecs[idx].rm);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            waits++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL issue_timeout: vector %0d not accepted, required acceptance within 50 cycles", idx);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor: a transfer happens at the next posedge when valid&ready hold at negedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            checks++;
            n_out++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got r=%h flags=%b, required no output", r, flags);
            end else begin
                e = exp_q.pop_front();
                if (r !== e.r || flags !== e.f) begin
                    errors++;
                    $display("FAIL result: got r=%h flags=%b, required r=%h flags=%b", r, flags, e.r, e.f);
                end else begin
                    $display("result r=%h flags=%b ok", r, flags);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int acc;
        int seen;

        add_vec(32'h3FC00000, 32'h40000000, RNE, 32'h40400000, 5'b00000); // 0
        add_vec(32'h3F800001, 32'h3F800001, RNE, 32'h3F800002, 5'b00001); // 1
        add_vec(32'h3F800001, 32'h3F800001, RTZ, 32'h3F800002, 5'b00001);
        add_vec(32'h3F800001, 32'h3F800001, RUP, 32'h3F800003, 5'b00001);
        add_vec(32'h3F800001, 32'h3F800001, RDN, 32'h3F800002, 5'b00001);
        add_vec(32'hBF800001, 32'h3F800001, RDN, 32'hBF800003, 5'b00001); // 5
        add_vec(32'hBF800001, 32'h3F800001, RUP, 32'hBF800002, 5'b00001);
        add_vec(32'h7F000000, 32'h7F000000, RNE, 32'h7F800000, 5'b00101);
        add_vec(32'h7F000000, 32'h7F000000, RTZ, 32'h7F7FFFFF, 5'b00101);
        add_vec(32'hFF000000, 32'h7F000000, RDN, 32'hFF800000, 5'b00101);
        add_vec(32'hFF000000, 32'h7F000000, RUP, 32'hFF7FFFFF, 5'b00101); // 10
        add_vec(32'h7F800000, 32'h00000000, RNE, 32'h7FC00000, 5'b10000);
        add_vec(32'h7FC00000, 32'h3F800000, RNE, 32'h7FC00000, 5'b10000);
        add_vec(32'hFF800000, 32'h40000000, RNE, 32'hFF800000, 5'b00000);
        add_vec(32'h80000000, 32'h3F800000, RNE, 32'h80000000, 5'b00000);
        add_vec(32'h00800000, 32'h3F000000, RNE, 32'h00000000, 5'b00011); // 15
        add_vec(32'h80800000, 32'h3F000000, RNE, 32'h80000000, 5'b00011);
        add_vec(32'h00400000, 32'h40000000, RNE, 32'h00800000, 5'b00000);
        add_vec(32'h00400000, 32'h40800000, RNE, 32'h01000000, 5'b00000);
        add_vec(32'h3F800001, 32'h3FFFFFFE, RNE, 32'h40000000, 5'b00001);
        add_vec(32'h3F800001, 32'h3FFFFFFE, RTZ, 32'h3FFFFFFF, 5'b00001); // 20
        add_vec(32'h3FC00000, 32'h3F800001, RNE, 32'h3FC00002, 5'b00001);
        add_vec(32'h3FC00000, 32'h3F800003, RNE, 32'h3FC00004, 5'b00001);
        add_vec(32'hBF800000, 32'h40000000, RNE, 32'hC0000000, 5'b00000);
        add_vec(32'h3FFFFFFF, 32'h3FFFFFFF, RUP, 32'h407FFFFF, 5'b00001);

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; round_mode = RNE; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_r",         r,              32'd0);
        check("reset_flags",     32'(flags),     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Latency: accepted on the first edge after reset, out_valid in cycle 3.
        issue(0, waits);
        check("first_accept_waits", 32'(waits), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("latency_cycle%0d", k), 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 1; i < vecs.size(); i++) begin
            issue(i, waits);
        end
        wait_drain();

        // Backpressure: try six back-to-back issues with the consumer stalled.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid   = 1'b1;
            a          = vecs[7 + acc].a;
            b          = vecs[7 + acc].b;
            round_mode = vecs[7 + acc].rm;
            @(negedge clk);
            if (c >= 3) begin
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_r_held", r, exp_q[0].r);
            end
            if (in_ready) begin
                exp_q.push_back({vecs[7 + acc].r, vecs[7 + acc].f});
                $display("issue  #%0d a=%h b=%h rm=%b (stalled)", 7 + acc, vecs[7 + acc].a,
                         vecs[7 + acc].b, vecs[7 + acc].rm);
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stall_accepted", 32'(acc), 32'd3);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset with two operations in flight.
        out_ready = 1'b0;
        issue(1, waits);
        issue(2, waits);
        @(posedge clk);
        @(negedge clk);
        check("preflush_out_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_r",         r,              32'd0);
        check("rst_flags",     32'(flags),     32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        seen = n_out;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) @(negedge clk);
        check("post_rst_no_output", 32'(n_out - seen), 32'd0);
        @(posedge clk); #1;

        issue(21, waits);
        check("post_rst_accept_waits", 32'(waits), 32'd0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
